video_bus_master_pixel_writer: RTL

VIDEO_BUS_MASTER_PIXEL_WRITER -- requirements
Module: video_bus_master_pixel_writer

---
 rtl/video_bus_master_pkg.sv | 21 ++
 rtl/video_bus_master_pixel_writer_if.sv | 49 ++++
 rtl/pixel_cmd_fifo.sv | 47 ++++
 rtl/video_bus_master_pixel_writer.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/video_bus_master_pkg.sv
// ============================================================================
// video_bus_master_pkg : shared FSM state type and command opcodes
// Rev 1.0
// ============================================================================
`default_nettype none

package video_bus_master_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOAD     = 2'd1,
        ISSUE    = 2'd2,
        WAIT_ACK = 2'd3
    } vbm_state_e;

    localparam logic OP_WRITE = 1'b0;
    localparam logic OP_READ  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/video_bus_master_pixel_writer_if.sv
// ============================================================================
// video_bus_master_pixel_writer_if : command, bus-master and status signals
// Rev 1.0
// ============================================================================
`default_nettype none

interface video_bus_master_pixel_writer_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 30,
    parameter int X_W    = 9,
    parameter int Y_W    = 8
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic                cmd_op;
    logic [X_W-1:0]      cmd_x;
    logic [Y_W-1:0]      cmd_y;
    logic [X_W-1:0]      cmd_len;
    logic [DATA_W-1:0]   cmd_color;
    logic [ADDR_W-1:0]   bm_address;
    logic [DATA_W/8-1:0] bm_byte_enable;
    logic                bm_read;
    logic                bm_write;
    logic [DATA_W-1:0]   bm_write_data;
    logic                bm_acknowledge;
    logic [DATA_W-1:0]   bm_read_data;
    logic                rd_valid;
    logic [DATA_W-1:0]   rd_data;
    logic                busy;
    logic                timeout_err;
    logic                err_clear;

    modport master (
        input  cmd_valid, cmd_op, cmd_x, cmd_y, cmd_len, cmd_color,
               bm_acknowledge, bm_read_data, err_clear,
        output cmd_ready, bm_address, bm_byte_enable, bm_read, bm_write,
               bm_write_data, rd_valid, rd_data, busy, timeout_err
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_x, cmd_y, cmd_len, cmd_color,
               bm_acknowledge, bm_read_data, err_clear,
        input  cmd_ready, bm_address, bm_byte_enable, bm_read, bm_write,
               bm_write_data, rd_valid, rd_data, busy, timeout_err
    );

endinterface

`default_nettype wire

// File: rtl/pixel_cmd_fifo.sv
// ============================================================================
// pixel_cmd_fifo : synchronous command FIFO, power-of-two depth
// Rev 1.0
// ============================================================================
`default_nettype none

module pixel_cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             push_i,
    input  wire logic [WIDTH-1:0] data_i,
    input  wire logic             pop_i,
    output logic      [WIDTH-1:0] data_o,
    output logic                  full_o,
    output logic                  empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end

    // Extra pointer bit distinguishes full from empty when indices match
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

endmodule

`default_nettype wire

// File: rtl/video_bus_master_pixel_writer.sv
// ============================================================================
// video_bus_master_pixel_writer : queued span writer / pixel reader bus master
// Optional readback of single pixels enabled by macro VBM_READBACK_EN. Rev 1.0
// ============================================================================
`default_nettype none

module video_bus_master_pixel_writer
    import video_bus_master_pkg::*;
#(
    parameter int                DATA_W      = 8,
    parameter int                ADDR_W      = 30,
    parameter int                X_W         = 9,
    parameter int                Y_W         = 8,
    parameter int                LINE_SHIFT  = 10,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                FIFO_DEPTH  = 8,
    parameter int                ACK_TIMEOUT = 1023
) (
    input  wire logic                      clk,
    input  wire logic                      reset,
    video_bus_master_pixel_writer_if.master bus
);
    localparam int BYTES   = DATA_W / 8;
    localparam int ENTRY_W = 1 + X_W + Y_W + X_W + DATA_W;
    localparam int TMR_W   = $clog2(ACK_TIMEOUT + 1);

    vbm_state_e          state_q;
    logic                op_q;
    logic [X_W-1:0]      x_q;
    logic [Y_W-1:0]      y_q;
    logic [X_W-1:0]      rem_q;
    logic [DATA_W-1:0]   color_q;
    logic [TMR_W-1:0]    tmr_q;
    logic [ADDR_W-1:0]   bm_address_q;
    logic [DATA_W-1:0]   bm_write_data_q;
    logic                bm_read_q;
    logic                bm_write_q;
    logic                timeout_err_q;

    logic [ENTRY_W-1:0]  w_head;
    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;
    logic [ADDR_W-1:0]   w_addr;
    logic                w_head_op;
    logic [X_W-1:0]      w_head_len;

    assign w_push     = bus.cmd_valid && !w_full;
    assign w_pop      = (state_q == LOAD);
    assign w_head_op  = w_head[ENTRY_W-1];
    assign w_head_len = w_head[DATA_W +: X_W];

    pixel_cmd_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (w_push),
        .data_i  ({bus.cmd_op, bus.cmd_x, bus.cmd_y, bus.cmd_len, bus.cmd_color}),
        .pop_i   (w_pop),
        .data_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    assign w_addr = BASE_ADDR + (ADDR_W'(y_q) << LINE_SHIFT) + ADDR_W'(x_q) * ADDR_W'(BYTES);

`ifdef VBM_READBACK_EN
    logic              rd_valid_q;
    logic [DATA_W-1:0] rd_data_q;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            op_q            <= OP_WRITE;
            x_q             <= '0;
            y_q             <= '0;
            rem_q           <= '0;
            color_q         <= '0;
            tmr_q           <= '0;
            bm_address_q    <= '0;
            bm_write_data_q <= '0;
            bm_read_q       <= 1'b0;
            bm_write_q      <= 1'b0;
            timeout_err_q   <= 1'b0;
`ifdef VBM_READBACK_EN
            rd_valid_q      <= 1'b0;
            rd_data_q       <= '0;
`endif
        end else begin
`ifdef VBM_READBACK_EN
            rd_valid_q <= 1'b0;
`endif
            // A timeout in the same cycle overrides this clear further down
            if (bus.err_clear) timeout_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!w_empty) state_q <= LOAD;
                end
                LOAD: begin
                    {op_q, x_q, y_q, rem_q, color_q} <= w_head;
                    if (w_head_op == OP_READ) begin
`ifdef VBM_READBACK_EN
                        rem_q   <= X_W'(1);
                        state_q <= ISSUE;
`else
                        state_q <= IDLE;
`endif
                    end else if (w_head_len == '0) begin
                        state_q <= IDLE;
                    end else begin
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    bm_address_q    <= w_addr;
                    bm_write_data_q <= color_q;
                    bm_read_q       <= (op_q == OP_READ);
                    bm_write_q      <= (op_q == OP_WRITE);
                    tmr_q           <= '0;
                    state_q         <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (bus.bm_acknowledge) begin
                        bm_read_q  <= 1'b0;
                        bm_write_q <= 1'b0;
`ifdef VBM_READBACK_EN
                        if (op_q == OP_READ) begin
                            rd_valid_q <= 1'b1;
                            rd_data_q  <= bus.bm_read_data;
                        end
`endif
                        if (rem_q == X_W'(1)) begin
                            state_q <= IDLE;
                        end else begin
                            rem_q   <= rem_q - X_W'(1);
                            x_q     <= x_q + X_W'(1);
                            state_q <= ISSUE;
                        end
                    end else if (tmr_q == TMR_W'(ACK_TIMEOUT - 1)) begin
                        bm_read_q     <= 1'b0;
                        bm_write_q    <= 1'b0;
                        timeout_err_q <= 1'b1;
                        state_q       <= IDLE;
                    end else begin
                        tmr_q <= tmr_q + TMR_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready      = !w_full;
    assign bus.bm_address     = bm_address_q;
    assign bus.bm_write_data  = bm_write_data_q;
    assign bus.bm_read        = bm_read_q;
    assign bus.bm_write       = bm_write_q;
    assign bus.bm_byte_enable = (bm_read_q || bm_write_q) ? '1 : '0;
    assign bus.busy           = !w_empty || (state_q != IDLE);
    assign bus.timeout_err    = timeout_err_q;

`ifdef VBM_READBACK_EN
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = rd_data_q;
`else
    logic w_unused_rd;
    assign w_unused_rd  = ^bus.bm_read_data;
    assign bus.rd_valid = 1'b0;
    assign bus.rd_data  = '0;
`endif

endmodule

`default_nettype wire
